neural_stream_packer: RTL and testbench

NEURAL_STREAM_PACKER -- requirements
Module: neural_stream_packer

---
 rtl/neural_stream_packer.sv | 187 ++++++++++++++++++
 tb/tb_neural_stream_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/neural_stream_packer.sv
// neural_stream_packer
//   Packs PACK consecutive IN_W-bit sample words into one OUT_W-bit word and
//   queues the packed words in a circular buffer that a host drains with rden.
//
// Parameters
//   IN_W     width of one input sample word
//   PACK     input words per output word (1..8), OUT_W = IN_W*PACK
//   DEPTH    buffer depth in output words (power of 2, >= 4)
//   SWAP     1: first word of a group in dout LSBs; 0: first word in MSBs
//   OVF_MODE 0: latch-and-stop on overflow; 1: drop-and-continue
//
// Ports
//   bus_clk        clock, rising edge
//   reset_n        synchronous active-low reset
//   open           host pipe open; low clears the block like a soft reset
//   din / wen      sample word and its valid strobe
//   rden           host read strobe; pops when not empty
//   dout           last popped word, held until the next pop
//   empty          no stored output word
//   eof            end-of-file (overflow latched and buffer drained, mode 0)
//   fifo_overflow  sticky; set when a completed group finds no room
//   level          stored output word count
//   drop_cnt       discarded output words (mode 1), saturating
module neural_stream_packer #(
  parameter int IN_W     = 16,
  parameter int PACK     = 2,
  parameter int DEPTH    = 2048,
  parameter int SWAP     = 1,
  parameter int OVF_MODE = 0
) (
  input  logic                      bus_clk,
  input  logic                      reset_n,
  input  logic                      open,
  input  logic [IN_W-1:0]           din,
  input  logic                      wen,
  input  logic                      rden,
  output logic [IN_W*PACK-1:0]      dout,
  output logic                      empty,
  output logic                      eof,
  output logic                      fifo_overflow,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               drop_cnt
);

  localparam int OUT_W = IN_W * PACK;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int PW    = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PACK - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [PW-1:0]   phase_q, phase_d;
  logic [IN_W-1:0] slot_q [PACK];
  logic [IN_W-1:0] slot_d [PACK];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;
  logic [OUT_W-1:0] dout_q;

  logic [OUT_W-1:0] mem [DEPTH];

  logic             accept;
  logic             group_done;
  logic             pop_ok;
  logic             push_ok;
  logic             ovf_event;
  logic [OUT_W-1:0] packed_word;

  // The last slot of a group is never registered: the incoming word is
  // combined with the earlier slots so the group is pushed on its final beat.
  for (genvar gi = 0; gi < PACK; gi++) begin : g_slot
    localparam int POS = (SWAP != 0) ? gi : (PACK - 1 - gi);
    if (gi == PACK - 1) begin : g_last
      assign packed_word[POS*IN_W +: IN_W] = din;
    end else begin : g_held
      assign packed_word[POS*IN_W +: IN_W] = slot_q[gi];
    end
  end

  // In latch-and-stop mode an overflow freezes intake until close/reset.
  assign accept     = open && wen && ((OVF_MODE != 0) || !ovf_q);
  assign group_done = accept && (phase_q == LAST_PHASE);
  // A pop needs a stored word; a same-cycle push does not count toward it.
  assign pop_ok     = open && rden && (level_q != '0);
  // A full buffer still takes a push when a word leaves in the same cycle.
  assign push_ok    = group_done && ((level_q != FULL_LEVEL) || pop_ok);
  assign ovf_event  = group_done && !push_ok;

  always_comb begin
    phase_d  = phase_q;
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (!open) begin
      // Closing the pipe discards everything, including a partial group.
      phase_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (accept) begin
        if (group_done) begin
          phase_d = '0;
        end else begin
          slot_d[phase_q] = din;
          phase_d         = phase_q + PW'(1);
        end
      end

      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (push_ok && !pop_ok) begin
        level_d = level_q + LW'(1);
      end else if (pop_ok && !push_ok) begin
        level_d = level_q - LW'(1);
      end

      if (ovf_event) begin
        ovf_d = 1'b1;
        if ((OVF_MODE != 0) && (drop_q != 16'hFFFF)) begin
          drop_d = drop_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      for (int i = 0; i < PACK; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      phase_q  <= phase_d;
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage array: write port only, no reset, so it maps onto block RAM.
  always_ff @(posedge bus_clk) begin
    if (reset_n && push_ok) begin
      mem[wr_ptr_q] <= packed_word;
    end
  end

  // Registered read port doubles as the dout holding register. When the
  // buffer is full and a push and pop hit the same address, the read sees
  // the old (popped) word.
  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else if (pop_ok) begin
      dout_q <= mem[rd_ptr_q];
    end
  end

  assign dout          = dout_q;
  assign empty         = (level_q == '0);
  assign level         = level_q;
  assign fifo_overflow = ovf_q;
  assign drop_cnt      = drop_q;
  assign eof           = (OVF_MODE == 0) ? (ovf_q && (level_q == '0)) : 1'b0;

endmodule

// File: tb/tb_neural_stream_packer.sv
// Bench for neural_stream_packer. Two instances share stimulus:
//   dut_a: DEPTH=4, PACK=2, SWAP=1, OVF_MODE=0 (latch-and-stop)
//   dut_b: DEPTH=4, PACK=2, SWAP=0, OVF_MODE=1 (drop-and-continue)
// A queue-based model of each instance is advanced once per clock.
module tb_neural_stream_packer;

  logic        clk;
  logic        rst_n;
  logic        open_i;
  logic [15:0] din_i;
  logic        wen_i;
  logic        rden_i;

  logic [31:0] a_dout, b_dout;
  logic        a_empty, b_empty, a_eof, b_eof, a_ovf, b_ovf;
  logic [2:0]  a_level, b_level;
  logic [15:0] a_drop, b_drop;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [15:0] part_a[$];
  logic [15:0] part_b[$];
  bit          ovf_m [2];
  int          drop_m [2];
  logic [31:0] dout_m [2];

  neural_stream_packer #(.IN_W(16), .PACK(2), .DEPTH(4), .SWAP(1), .OVF_MODE(0)) dut_a (
    .bus_clk(clk), .reset_n(rst_n), .open(open_i), .din(din_i), .wen(wen_i), .rden(rden_i),
    .dout(a_dout), .empty(a_empty), .eof(a_eof), .fifo_overflow(a_ovf),
    .level(a_level), .drop_cnt(a_drop)
  );

  neural_stream_packer #(.IN_W(16), .PACK(2), .DEPTH(4), .SWAP(0), .OVF_MODE(1)) dut_b (
    .bus_clk(clk), .reset_n(rst_n), .open(open_i), .din(din_i), .wen(wen_i), .rden(rden_i),
    .dout(b_dout), .empty(b_empty), .eof(b_eof), .fifo_overflow(b_ovf),
    .level(b_level), .drop_cnt(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: instance 0 is SWAP=1/mode 0, instance 1 is SWAP=0/mode 1.
  task automatic model_step(input int m, input logic rv, input logic o, input logic w,
                            input logic [15:0] d, input logic r);
    logic [31:0] q[$];
    logic [15:0] part[$];
    logic [31:0] word;
    if (m == 0) begin q = q_a; part = part_a; end
    else        begin q = q_b; part = part_b; end
    if (!rv) begin
      q.delete(); part.delete();
      ovf_m[m] = 1'b0; drop_m[m] = 0; dout_m[m] = 32'h0;
    end else if (!o) begin
      q.delete(); part.delete();
      ovf_m[m] = 1'b0; drop_m[m] = 0;
    end else begin
      // pop first: a full buffer with a pop has room for this cycle's push
      if (r && q.size() > 0) dout_m[m] = q.pop_front();
      if (w && (m == 1 || !ovf_m[m])) begin
        part.push_back(d);
        if (part.size() == 2) begin
          word = (m == 0) ? {part[1], part[0]} : {part[0], part[1]};
          part.delete();
          if (q.size() < 4) q.push_back(word);
          else begin
            ovf_m[m] = 1'b1;
            if (m == 1 && drop_m[m] < 65535) drop_m[m] = drop_m[m] + 1;
          end
        end
      end
    end
    if (m == 0) begin q_a = q; part_a = part; end
    else        begin q_b = q; part_b = part; end
  endtask

  task automatic tick(input logic rv, input logic o, input logic w,
                      input logic [15:0] d, input logic r);
    rst_n = rv; open_i = o; wen_i = w; din_i = d; rden_i = r;
    model_step(0, rv, o, w, d, r);
    model_step(1, rv, o, w, d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    tick(1'b1, 1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic read_word();
    tick(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    $display("[TB] read: a_dout=%h b_dout=%h a_level=%0d b_level=%0d", a_dout, b_dout, a_level, b_level);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_reset();
    // Reset with wen/rden active must still win.
    tick(1'b0, 1'b1, 1'b1, 16'h5A5A, 1'b1);
    do_reset();
    tests_run++; if (a_empty !== 1'b1 || b_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty a=%b b=%b expected 1", a_empty, b_empty); end
    tests_run++; if (a_level !== 3'd0 || b_level !== 3'd0) begin tests_failed++; $display("FAIL reset_level a=%0d b=%0d expected 0", a_level, b_level); end
    tests_run++; if (a_ovf !== 1'b0 || b_ovf !== 1'b0 || a_eof !== 1'b0 || b_eof !== 1'b0) begin tests_failed++; $display("FAIL reset_flags ovf=%b%b eof=%b%b expected 0", a_ovf, b_ovf, a_eof, b_eof); end
    tests_run++; if (a_dout !== 32'h0 || b_dout !== 32'h0 || a_drop !== 16'h0 || b_drop !== 16'h0) begin tests_failed++; $display("FAIL reset_data dout=%h/%h drop=%h/%h expected 0", a_dout, b_dout, a_drop, b_drop); end
  endtask

  task automatic test_pack_swap();
    do_reset();
    write_word(16'h1111);
    tests_run++; if (a_empty !== 1'b1) begin tests_failed++; $display("FAIL half_group_empty got=%b expected 1", a_empty); end
    write_word(16'h2222);
    tests_run++; if (a_empty !== 1'b0 || a_level !== 3'd1) begin tests_failed++; $display("FAIL push_latency empty=%b level=%0d expected 0/1", a_empty, a_level); end
    read_word();
    tests_run++; if (a_dout !== 32'h2222_1111) begin tests_failed++; $display("FAIL swap1_dout got=%h expected 22221111", a_dout); end
    tests_run++; if (b_dout !== 32'h1111_2222) begin tests_failed++; $display("FAIL swap0_dout got=%h expected 11112222", b_dout); end
    tests_run++; if (a_empty !== 1'b1 || b_empty !== 1'b1) begin tests_failed++; $display("FAIL empty_after_pop a=%b b=%b expected 1", a_empty, b_empty); end
    // push and pop on an empty buffer: pop ignored, dout held, level 1
    write_word(16'h3333);
    tick(1'b1, 1'b1, 1'b1, 16'h4444, 1'b1);
    tests_run++; if (a_level !== 3'd1 || a_dout !== 32'h2222_1111) begin tests_failed++; $display("FAIL push_pop_empty level=%0d dout=%h expected 1/22221111", a_level, a_dout); end
    read_word();
    tests_run++; if (a_dout !== 32'h4444_3333 || b_dout !== 32'h3333_4444) begin tests_failed++; $display("FAIL second_group a=%h b=%h expected 44443333/33334444", a_dout, b_dout); end
    // read while empty leaves dout alone
    read_word();
    tests_run++; if (a_dout !== 32'h4444_3333 || a_level !== 3'd0) begin tests_failed++; $display("FAIL read_empty dout=%h level=%0d expected 44443333/0", a_dout, a_level); end
  endtask

  task automatic test_ovf_stop();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 10; i++) write_word(16'(16'h1000 + i));
    tests_run++; if (a_level !== 3'd4 || a_ovf !== 1'b1 || a_eof !== 1'b0) begin tests_failed++; $display("FAIL stop_full level=%0d ovf=%b eof=%b expected 4/1/0", a_level, a_ovf, a_eof); end
    tests_run++; if (a_drop !== 16'd0 || b_drop !== 16'd1) begin tests_failed++; $display("FAIL drop_after_10 a=%0d b=%0d expected 0/1", a_drop, b_drop); end
    for (int g = 0; g < 4; g++) begin
      read_word();
      exp = {16'(16'h1000 + 2*g + 1), 16'(16'h1000 + 2*g)};
      tests_run++; if (a_dout !== exp) begin tests_failed++; $display("FAIL drain_%0d got=%h expected %h", g, a_dout, exp); end
    end
    tests_run++; if (a_eof !== 1'b1 || a_empty !== 1'b1) begin tests_failed++; $display("FAIL eof_after_drain eof=%b empty=%b expected 1/1", a_eof, a_empty); end
    write_word(16'hDEAD);
    write_word(16'hBEEF);
    tests_run++; if (a_level !== 3'd0 || a_eof !== 1'b1 || a_ovf !== 1'b1) begin tests_failed++; $display("FAIL writes_after_stop level=%0d eof=%b ovf=%b expected 0/1/1", a_level, a_eof, a_ovf); end
  endtask

  task automatic test_ovf_drop();
    do_reset();
    for (int i = 0; i < 14; i++) write_word(16'(16'h2000 + i));
    tests_run++; if (b_level !== 3'd4 || b_drop !== 16'd3) begin tests_failed++; $display("FAIL drop_14 level=%0d drop=%0d expected 4/3", b_level, b_drop); end
    tests_run++; if (b_ovf !== 1'b1 || b_eof !== 1'b0) begin tests_failed++; $display("FAIL drop_flags ovf=%b eof=%b expected 1/0", b_ovf, b_eof); end
    write_word(16'h3000);
    write_word(16'h3001);
    tests_run++; if (b_drop !== 16'd4) begin tests_failed++; $display("FAIL drop_16 got=%0d expected 4", b_drop); end
  endtask

  task automatic test_full_push_pop_close();
    do_reset();
    for (int i = 0; i < 8; i++) write_word(16'(16'h4000 + i));
    write_word(16'h5000);
    tick(1'b1, 1'b1, 1'b1, 16'h5001, 1'b1);
    tests_run++; if (a_level !== 3'd4 || b_level !== 3'd4 || a_ovf !== 1'b0 || b_ovf !== 1'b0) begin tests_failed++; $display("FAIL full_push_pop level=%0d/%0d ovf=%b/%b expected 4/4/0/0", a_level, b_level, a_ovf, b_ovf); end
    tests_run++; if (a_dout !== 32'h4001_4000) begin tests_failed++; $display("FAIL full_pop_data got=%h expected 40014000", a_dout); end
    // overflow b, then close both
    write_word(16'h6000); write_word(16'h6001);
    tick(1'b1, 1'b0, 1'b1, 16'h7000, 1'b1);
    tests_run++; if (a_level !== 3'd0 || b_level !== 3'd0 || a_empty !== 1'b1 || b_empty !== 1'b1) begin tests_failed++; $display("FAIL close_level level=%0d/%0d empty=%b/%b expected 0/0/1/1", a_level, b_level, a_empty, b_empty); end
    tests_run++; if (a_ovf !== 1'b0 || b_ovf !== 1'b0 || b_drop !== 16'd0) begin tests_failed++; $display("FAIL close_flags ovf=%b/%b drop=%0d expected 0/0/0", a_ovf, b_ovf, b_drop); end
  endtask

  task automatic test_mid_group_reset();
    do_reset();
    write_word(16'h9999);
    do_reset();
    write_word(16'hAAAA);
    write_word(16'hBBBB);
    read_word();
    tests_run++; if (a_dout !== 32'hBBBB_AAAA || b_dout !== 32'hAAAA_BBBB) begin tests_failed++; $display("FAIL mid_reset a=%h b=%h expected bbbbaaaa/aaaabbbb", a_dout, b_dout); end
    // same via close mid-group
    write_word(16'h7777);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    write_word(16'hCCCC);
    write_word(16'hDDDD);
    read_word();
    tests_run++; if (a_dout !== 32'hDDDD_CCCC) begin tests_failed++; $display("FAIL mid_close got=%h expected ddddcccc", a_dout); end
  endtask

  task automatic test_random();
    logic rv, o, w, r;
    logic [15:0] d;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rv = ($urandom_range(0, 199) != 0);
      o  = ($urandom_range(0, 99) >= 3);
      w  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 35);
      d  = 16'($urandom);
      tick(rv, o, w, d, r);
      tests_run++; if (a_dout !== dout_m[0] || b_dout !== dout_m[1]) begin tests_failed++; $display("FAIL rand_dout c=%0d a=%h/%h b=%h/%h (got/expected)", c, a_dout, dout_m[0], b_dout, dout_m[1]); end
      tests_run++; if (a_level !== 3'(q_a.size()) || b_level !== 3'(q_b.size())) begin tests_failed++; $display("FAIL rand_level c=%0d a=%0d/%0d b=%0d/%0d (got/expected)", c, a_level, q_a.size(), b_level, q_b.size()); end
      tests_run++; if (a_empty !== (q_a.size() == 0) || b_empty !== (q_b.size() == 0)) begin tests_failed++; $display("FAIL rand_empty c=%0d a=%b b=%b", c, a_empty, b_empty); end
      tests_run++; if (a_ovf !== ovf_m[0] || b_ovf !== ovf_m[1]) begin tests_failed++; $display("FAIL rand_ovf c=%0d a=%b/%b b=%b/%b (got/expected)", c, a_ovf, ovf_m[0], b_ovf, ovf_m[1]); end
      tests_run++; if (a_eof !== (ovf_m[0] && q_a.size() == 0) || b_eof !== 1'b0) begin tests_failed++; $display("FAIL rand_eof c=%0d a=%b b=%b", c, a_eof, b_eof); end
      tests_run++; if (a_drop !== 16'd0 || b_drop !== 16'(drop_m[1])) begin tests_failed++; $display("FAIL rand_drop c=%0d a=%0d b=%0d/%0d (got/expected)", c, a_drop, b_drop, drop_m[1]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; open_i = 1'b1; din_i = 16'h0; wen_i = 1'b0; rden_i = 1'b0;
    test_reset();
    test_pack_swap();
    test_ovf_stop();
    test_ovf_drop();
    test_full_push_pop_close();
    test_mid_group_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
